// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared single-precision constants and types for the fp datapath
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    typedef enum logic [2:0] {
        IDLE,
        UNPACK,
        DIVIDE,
        NORM,
        DONE
    } div_state_t;

    typedef struct packed {
        logic invalid;
        logic div_by_zero;
        logic overflow;
        logic underflow;
    } fp_flags_t;

    typedef struct packed {
        logic is_zero;
        logic is_inf;
        logic is_nan;
        logic is_denorm;
    } fp_class_t;

endpackage

// File: rtl/ieee_divide_seq_if.sv
// rtl/ieee_divide_seq_if.sv - operand/result handshake bundle for the divider
interface ieee_divide_seq_if;
    import fp_pkg::*;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] c;
    fp_flags_t   flags;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, flags
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, flags
    );

endinterface

// File: rtl/fp_classify.sv
// rtl/fp_classify.sv - combinational unpack of one single-precision operand
module fp_classify
    import fp_pkg::*;
(
    input  logic [31:0]      x,
    output logic             sign,
    output logic [EXP_W-1:0] expo,
    output logic [FRAC_W:0]  mant,
    output fp_class_t        cls
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;
    logic              e_zero;
    logic              e_ones;
    logic              f_zero;

    assign e      = x[FRAC_W +: EXP_W];
    assign f      = x[FRAC_W-1:0];
    assign e_zero = (e == '0);
    assign e_ones = (e == '1);
    assign f_zero = (f == '0);

    assign sign = x[31];
    assign expo = e;
    // Hidden bit is only set for normals; denormal mantissas are never used downstream.
    assign mant = {~e_zero, f};

    assign cls.is_zero   = e_zero & f_zero;
    assign cls.is_denorm = e_zero & ~f_zero;
    assign cls.is_inf    = e_ones & f_zero;
    assign cls.is_nan    = e_ones & ~f_zero;

endmodule

// File: rtl/ieee_divide_seq.sv
// rtl/ieee_divide_seq.sv - iterative single-precision divider, restoring radix-2, round toward zero
module ieee_divide_seq #(
    parameter int EXP_W  = fp_pkg::EXP_W,
    parameter int FRAC_W = fp_pkg::FRAC_W,
    parameter int BIAS   = fp_pkg::BIAS
) (
    input logic              clk,
    input logic              rst_n,
    ieee_divide_seq_if.slave bus
);
    import fp_pkg::*;

    localparam int MW = FRAC_W + 1;
    localparam int QW = FRAC_W + 2;
    localparam int RW = FRAC_W + 3;
    localparam int EW = EXP_W + 2;
    localparam int CW = $clog2(QW);
    localparam logic [EW-1:0] E_MAX = EW'((1 << EXP_W) - 1);

    div_state_t              state;
    logic [31:0]             a_q;
    logic [31:0]             b_q;
    logic                    sign_q;
    logic signed [EW-1:0]    e_q;
    logic [RW-1:0]           rem_q;
    logic [MW-1:0]           div_q;
    logic [QW-1:0]           q_q;
    logic [CW-1:0]           cnt_q;
    logic                    out_valid_q;
    logic [31:0]             c_q;
    fp_flags_t               flags_q;

    logic                    sa;
    logic                    sb;
    logic [EXP_W-1:0]        ea;
    logic [EXP_W-1:0]        eb;
    logic [MW-1:0]           ma;
    logic [MW-1:0]           mb;
    fp_class_t               ca;
    fp_class_t               cb;

    fp_classify u_class_a (.x(a_q), .sign(sa), .expo(ea), .mant(ma), .cls(ca));
    fp_classify u_class_b (.x(b_q), .sign(sb), .expo(eb), .mant(mb), .cls(cb));

    logic                    za;
    logic                    zb;
    logic                    res_sign;
    logic signed [EW-1:0]    e_calc;

    // Denormals are flushed, so they take the same special-case paths as zero.
    assign za       = ca.is_zero | ca.is_denorm;
    assign zb       = cb.is_zero | cb.is_denorm;
    assign res_sign = sa ^ sb;
    assign e_calc   = EW'(ea) - EW'(eb) + EW'(BIAS);

    logic                    special;
    logic [31:0]             spec_c;
    fp_flags_t               spec_flags;

    always_comb begin
        special    = 1'b1;
        spec_c     = QNAN;
        spec_flags = '0;
        if (ca.is_nan || cb.is_nan) begin
            spec_flags.invalid = 1'b1;
        end else if ((za && zb) || (ca.is_inf && cb.is_inf)) begin
            spec_flags.invalid = 1'b1;
        end else if (ca.is_inf) begin
            spec_c = {res_sign, POS_INF[30:0]};
        end else if (zb) begin
            spec_c                 = {res_sign, POS_INF[30:0]};
            spec_flags.div_by_zero = 1'b1;
        end else if (za || cb.is_inf) begin
            spec_c = {res_sign, 31'b0};
        end else begin
            special = 1'b0;
            spec_c  = '0;
        end
    end

    logic                    ge;
    logic [RW-1:0]           diff;

    assign ge   = (rem_q >= RW'(div_q));
    assign diff = ge ? (rem_q - RW'(div_q)) : rem_q;

    logic signed [EW-1:0]    e_norm;
    logic [FRAC_W-1:0]       m_norm;
    logic                    ovf;
    logic                    unf;

    // The quotient lies in [2^23, 2^25); its top bit picks the normalising shift.
    assign e_norm = q_q[QW-1] ? e_q : (e_q - EW'(1));
    assign m_norm = q_q[QW-1] ? q_q[QW-2:1] : q_q[QW-3:0];
    assign unf    = e_norm[EW-1] || (e_norm == '0);
    assign ovf    = !e_norm[EW-1] && (e_norm >= E_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sign_q      <= 1'b0;
            e_q         <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            q_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            c_q         <= '0;
            flags_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q   <= bus.a;
                        b_q   <= bus.b;
                        state <= UNPACK;
                    end
                end
                UNPACK: begin
                    sign_q <= res_sign;
                    e_q    <= e_calc;
                    rem_q  <= RW'(ma);
                    div_q  <= mb;
                    q_q    <= '0;
                    cnt_q  <= '0;
                    if (special) begin
                        c_q         <= spec_c;
                        flags_q     <= spec_flags;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        state <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem_q <= {diff[RW-2:0], 1'b0};
                    q_q   <= {q_q[QW-2:0], ge};
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(QW - 1)) begin
                        state <= NORM;
                    end
                end
                NORM: begin
                    out_valid_q <= 1'b1;
                    state       <= DONE;
                    if (ovf) begin
                        c_q              <= {sign_q, POS_INF[30:0]};
                        flags_q.overflow <= 1'b1;
                    end else if (unf) begin
                        c_q               <= {sign_q, 31'b0};
                        flags_q.underflow <= 1'b1;
                    end else begin
                        c_q <= {sign_q, e_norm[EXP_W-1:0], m_norm};
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        c_q         <= '0;
                        flags_q     <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.c         = c_q;
    assign bus.flags     = flags_q;

endmodule

// File: tb/tb_ieee_divide_seq.sv
// tb/tb_ieee_divide_seq.sv - self-checking bench for ieee_divide_seq
module tb_ieee_divide_seq;
    import fp_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ieee_divide_seq_if bus ();

    ieee_divide_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%08h want=%08h", tag, got, want);
        end
    endtask

    // Quotient from integer division of the 24-bit significands, then truncated.
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] c, output logic [3:0] f, output int lat);
        int          ex, ey, e;
        logic [22:0] fx, fy;
        bit          zx, zy, ix, iy, nx, ny;
        logic        s;
        longint      q;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        fx = x[22:0];
        fy = y[22:0];
        zx = (ex == 0);
        zy = (ey == 0);
        ix = (ex == 255) && (fx == 0);
        iy = (ey == 255) && (fy == 0);
        nx = (ex == 255) && (fx != 0);
        ny = (ey == 255) && (fy != 0);
        s  = x[31] ^ y[31];
        f  = 4'b0000;
        lat = 1;
        c  = 32'h0;
        if (nx || ny) begin
            c = 32'h7FC00000; f = 4'b1000;
        end else if ((zx && zy) || (ix && iy)) begin
            c = 32'h7FC00000; f = 4'b1000;
        end else if (ix) begin
            c = {s, 8'hFF, 23'h0};
        end else if (zy) begin
            c = {s, 8'hFF, 23'h0}; f = 4'b0100;
        end else if (zx || iy) begin
            c = {s, 31'h0};
        end else begin
            lat = 27;
            q = ((longint'(fx) + 64'h800000) * 64'h1000000) / (longint'(fy) + 64'h800000);
            e = ex - ey + 127;
            if (q < 64'h1000000) begin
                e = e - 1;
                q = q * 2;
            end
            if (e >= 255) begin
                c = {s, 8'hFF, 23'h0}; f = 4'b0010;
            end else if (e <= 0) begin
                c = {s, 31'h0}; f = 4'b0001;
            end else begin
                c = {s, 8'(e), 23'(q >> 1)};
            end
        end
    endfunction

    function automatic logic [31:0] rnd_op();
        int          sel;
        logic [7:0]  e;
        logic [22:0] f;
        sel = $urandom_range(0, 9);
        f   = 23'($urandom);
        if (sel == 0)      e = ($urandom_range(0, 1) == 1) ? 8'hFF : 8'h00;
        else if (sel == 1) e = 8'($urandom_range(1, 254));
        else               e = 8'($urandom_range(110, 144));
        if ($urandom_range(0, 7) == 0) f = '0;
        return {1'($urandom), e, f};
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] ec,
                          input logic [3:0] ef, input int el, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, ":in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        bus.a        = x;
        bus.b        = y;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ":lat"}, lat, el);
        chk({tag, ":c"}, bus.c, ec);
        chk({tag, ":flags"}, {28'b0, bus.flags}, {28'b0, ef});
        if (bus.out_ready) begin
            @(posedge clk);
            #1;
            chk({tag, ":consumed"}, {31'b0, bus.out_valid}, 32'd0);
        end
    endtask

    logic [31:0] dir_a [8] = '{32'h40C00000, 32'h3F800000, 32'hC0000000, 32'h00000000,
                               32'h7F800840, 32'h7F000000, 32'h00800000, 32'h00010680};
    logic [31:0] dir_b [8] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                               32'h3F800000, 32'h3E800000, 32'h40000000, 32'h3F800000};
    logic [31:0] dir_c [8] = '{32'h40400000, 32'h3EAAAAAA, 32'hFF800000, 32'h7FC00000,
                               32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000};
    logic [3:0]  dir_f [8] = '{4'b0000, 4'b0000, 4'b0100, 4'b1000,
                               4'b1000, 4'b0010, 4'b0001, 4'b0000};
    int          dir_l [8] = '{27, 27, 1, 1, 1, 27, 27, 1};

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] x, y, ec;
        logic [3:0]  ef;
        int          el;

        bus.in_valid  = 1'b1;
        bus.a         = 32'h40C00000;
        bus.b         = 32'h40000000;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst:out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst:in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("rst:c", bus.c, 32'd0);
        chk("rst:flags", {28'b0, bus.flags}, 32'd0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle:out_valid", {31'b0, bus.out_valid}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(dir_a[i], dir_b[i], dir_c[i], dir_f[i], dir_l[i], $sformatf("dir%0d", i));
        end

        // Back-pressure: result must hold while extra operands are offered.
        bus.out_ready = 1'b0;
        run_op(32'hC1200000, 32'h40800000, 32'hC0200000, 4'b0000, 27, "bp");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.a        = $urandom;
            bus.b        = $urandom;
            chk("bp:in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp:out_valid", {31'b0, bus.out_valid}, 32'd1);
            chk("bp:c", bus.c, 32'hC0200000);
            chk("bp:flags", {28'b0, bus.flags}, 32'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp:release_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("bp:release_ready", {31'b0, bus.in_ready}, 32'd1);
        run_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27, "bp_next");

        // Asynchronous reset in the middle of the iteration.
        @(negedge clk);
        bus.a        = 32'h3F800000;
        bus.b        = 32'h40400000;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst:out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mid_rst:in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_rst:held", {31'b0, bus.out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27, "after_rst");

        for (int i = 0; i < 150; i++) begin
            x = rnd_op();
            y = rnd_op();
            model(x, y, ec, ef, el);
            run_op(x, y, ec, ef, el, $sformatf("rnd%0d_%08h_%08h", i, x, y));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
